// File: rtl/tao_xung_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tao_xung_pkg
//  Description : Shared encodings for the N-channel pulse generator:
//                config-select codes, channel mode codes and the minimum
//                effective period.
//  Revision    : 1.0 - initial release
// ============================================================================
package tao_xung_pkg;

    // cfg_sel encodings (value 3 is reserved and ignored)
    localparam logic [1:0] SEL_P    = 2'd0;
    localparam logic [1:0] SEL_H    = 2'd1;
    localparam logic [1:0] SEL_MODE = 2'd2;

    // Channel output modes
    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_TICK   = 1'b1;

    // Programmed periods below this value behave as this value
    localparam int unsigned MIN_PERIOD = 2;

endpackage : tao_xung_pkg
`default_nettype wire

// File: rtl/chia_xung_kenh.sv
`default_nettype none
// ============================================================================
//  Module      : chia_xung_kenh
//  Description : One pulse channel. Holds shadow (P, H, mode) registers that
//                accept config writes at any time, and active registers that
//                drive the period counter. Shadow values move to active only
//                at a period boundary or while the channel is disabled, so a
//                write never glitches or truncates the running period.
//  Ports       : clk_i     - clock, rising edge
//                rst_ni    - asynchronous active-low reset
//                en_i      - channel run enable
//                we_p_i    - write shadow period from data_i
//                we_h_i    - write shadow high time from data_i
//                we_mode_i - write shadow mode from data_i[0]
//                data_i    - write data
//                clko_o    - registered channel waveform
//                wrap_o    - registered strobe, high in cycle 0 of a period
//  Revision    : 1.0 - initial release
// ============================================================================
module chia_xung_kenh #(
    parameter int unsigned      CW    = 32,
    parameter logic [CW-1:0]    RST_P = '0,
    parameter logic [CW-1:0]    RST_H = '0
)(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          we_p_i,
    input  logic          we_h_i,
    input  logic          we_mode_i,
    input  logic [CW-1:0] data_i,
    output logic          clko_o,
    output logic          wrap_o
);
    import tao_xung_pkg::*;

    logic [CW-1:0] p_sh_q,   p_sh_d;
    logic [CW-1:0] h_sh_q,   h_sh_d;
    logic          m_sh_q,   m_sh_d;
    logic [CW-1:0] p_act_q,  p_act_d;
    logic [CW-1:0] h_act_q,  h_act_d;
    logic          m_act_q,  m_act_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          run_q;
    logic          clko_q,   clko_d;
    logic          wrap_q,   wrap_d;

    logic [CW-1:0] w_last;      // last counter value of the current period
    logic          w_new_per;   // this edge starts cycle 0 of a period

    // Pe-1 with P in {0,1} treated as the minimum period
    assign w_last = (p_act_q < CW'(MIN_PERIOD)) ? CW'(MIN_PERIOD - 1)
                                                : (p_act_q - CW'(1));

    always_comb begin
        p_sh_d    = we_p_i    ? data_i    : p_sh_q;
        h_sh_d    = we_h_i    ? data_i    : h_sh_q;
        m_sh_d    = we_mode_i ? data_i[0] : m_sh_q;

        p_act_d   = p_act_q;
        h_act_d   = h_act_q;
        m_act_d   = m_act_q;
        cnt_d     = '0;
        w_new_per = 1'b0;

        if (!en_i) begin
            // Idle: keep active tracking shadow so enable starts on fresh values
            p_act_d = p_sh_q;
            h_act_d = h_sh_q;
            m_act_d = m_sh_q;
        end else if (!run_q || (cnt_q >= w_last)) begin
            // Enable edge or wrap: old shadow is latched, so a write on this
            // same edge lands in shadow only and waits for the next wrap.
            p_act_d   = p_sh_q;
            h_act_d   = h_sh_q;
            m_act_d   = m_sh_q;
            w_new_per = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Outputs describe the cycle that begins at this edge
        wrap_d = en_i & w_new_per;
        clko_d = 1'b0;
        if (en_i) begin
            if (m_act_d == MODE_TICK) clko_d = w_new_per;
            else                      clko_d = (cnt_d < h_act_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_sh_q  <= RST_P;
            h_sh_q  <= RST_H;
            m_sh_q  <= MODE_SQUARE;
            p_act_q <= RST_P;
            h_act_q <= RST_H;
            m_act_q <= MODE_SQUARE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            clko_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            p_sh_q  <= p_sh_d;
            h_sh_q  <= h_sh_d;
            m_sh_q  <= m_sh_d;
            p_act_q <= p_act_d;
            h_act_q <= h_act_d;
            m_act_q <= m_act_d;
            cnt_q   <= cnt_d;
            run_q   <= en_i;
            clko_q  <= clko_d;
            wrap_q  <= wrap_d;
        end
    end

    assign clko_o = clko_q;
    assign wrap_o = wrap_q;

endmodule : chia_xung_kenh
`default_nettype wire

// File: rtl/tao_xung_n_kenh.sv
`default_nettype none
// ============================================================================
//  Module      : tao_xung_n_kenh
//  Description : N independent programmable pulse channels. The top decodes
//                the shared config write port into per-channel strobes; all
//                timing lives in chia_xung_kenh. Channel i resets to period
//                DIV0>>i with half of that as high time.
//  Ports       : clki     - clock, rising edge
//                rst_n    - asynchronous active-low reset
//                en       - per-channel run enable
//                cfg_we   - config write strobe
//                cfg_ch   - target channel (values >= NCH are ignored)
//                cfg_sel  - 0 period, 1 high time, 2 mode, 3 reserved
//                cfg_data - write value
//                clko     - per-channel waveforms
//                wrap     - per-channel cycle-0 strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module tao_xung_n_kenh #(
    parameter int unsigned NCH  = 3,
    parameter int unsigned CW   = 32,
    parameter int unsigned DIV0 = 100000000
)(
    input  logic           clki,
    input  logic           rst_n,
    input  logic [NCH-1:0] en,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_ch,
    input  logic [1:0]     cfg_sel,
    input  logic [CW-1:0]  cfg_data,
    output logic [NCH-1:0] clko,
    output logic [NCH-1:0] wrap
);
    import tao_xung_pkg::*;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_kenh
            localparam logic [CW-1:0] RST_P = CW'(DIV0 >> gi);
            localparam logic [CW-1:0] RST_H = CW'((DIV0 >> gi) / 2);

            logic w_hit;
            assign w_hit = cfg_we && (cfg_ch == 4'(gi));

            chia_xung_kenh #(
                .CW    (CW),
                .RST_P (RST_P),
                .RST_H (RST_H)
            ) u_kenh (
                .clk_i     (clki),
                .rst_ni    (rst_n),
                .en_i      (en[gi]),
                .we_p_i    (w_hit && (cfg_sel == SEL_P)),
                .we_h_i    (w_hit && (cfg_sel == SEL_H)),
                .we_mode_i (w_hit && (cfg_sel == SEL_MODE)),
                .data_i    (cfg_data),
                .clko_o    (clko[gi]),
                .wrap_o    (wrap[gi])
            );
        end
    endgenerate

endmodule : tao_xung_n_kenh
`default_nettype wire

// File: tb/tb_tao_xung_n_kenh.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tao_xung_n_kenh
//  Description : Self-checking bench for tao_xung_n_kenh (NCH=3, CW=8,
//                DIV0=8). A per-channel reference tracks the position inside
//                the current period and the parameters frozen for it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tao_xung_n_kenh;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DIV0 = 8;

    logic           clki = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           cfg_we;
    logic [3:0]     cfg_ch;
    logic [1:0]     cfg_sel;
    logic [CW-1:0]  cfg_data;
    logic [NCH-1:0] clko;
    logic [NCH-1:0] wrap;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    int sh_p [NCH];  int sh_h [NCH];  int sh_m [NCH];
    int cu_p [NCH];  int cu_h [NCH];  int cu_m [NCH];
    int pos  [NCH];  bit run  [NCH];
    bit exp_c[NCH];  bit exp_w[NCH];

    tao_xung_n_kenh #(.NCH(NCH), .CW(CW), .DIV0(DIV0)) dut (
        .clki     (clki),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .clko     (clko),
        .wrap     (wrap)
    );

    always #5 clki = ~clki;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            sh_p[c] = DIV0 >> c;  sh_h[c] = (DIV0 >> c) / 2;  sh_m[c] = 0;
            cu_p[c] = sh_p[c];    cu_h[c] = sh_h[c];          cu_m[c] = 0;
            pos[c] = 0;  run[c] = 1'b0;  exp_c[c] = 1'b0;  exp_w[c] = 1'b0;
        end
    endtask

    // One rising edge worth of behaviour, using the inputs the DUT sampled
    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int pe;
            pe = (cu_p[c] < 2) ? 2 : cu_p[c];
            if (!en[c]) begin
                run[c] = 1'b0;  pos[c] = 0;
                cu_p[c] = sh_p[c];  cu_h[c] = sh_h[c];  cu_m[c] = sh_m[c];
                exp_c[c] = 1'b0;  exp_w[c] = 1'b0;
            end else begin
                if (!run[c] || (pos[c] + 1 >= pe)) begin
                    pos[c] = 0;
                    cu_p[c] = sh_p[c];  cu_h[c] = sh_h[c];  cu_m[c] = sh_m[c];
                end else begin
                    pos[c] = pos[c] + 1;
                end
                run[c]   = 1'b1;
                exp_w[c] = (pos[c] == 0);
                exp_c[c] = (cu_m[c] == 1) ? (pos[c] == 0) : (pos[c] < cu_h[c]);
            end
        end
        if (cfg_we && (int'(cfg_ch) < NCH)) begin
            case (cfg_sel)
                2'd0: sh_p[cfg_ch] = int'(cfg_data);
                2'd1: sh_h[cfg_ch] = int'(cfg_data);
                2'd2: sh_m[cfg_ch] = int'(cfg_data[0]);
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            n_tests++;
            assert (clko[c] === exp_c[c]) else begin
                n_fail++;
                $error("FAIL clko[%0d] t=%0t observed=%b expected=%b", c, $time, clko[c], exp_c[c]);
            end
            n_tests++;
            assert (wrap[c] === exp_w[c]) else begin
                n_fail++;
                $error("FAIL wrap[%0d] t=%0t observed=%b expected=%b", c, $time, wrap[c], exp_w[c]);
            end
        end
    endtask

    // Drive inputs, take one edge, check just after it
    task automatic cyc(input logic [NCH-1:0] e, input logic we, input int ch,
                       input int sel, input int data);
        en       = e;
        cfg_we   = we;
        cfg_ch   = 4'(ch);
        cfg_sel  = 2'(sel);
        cfg_data = CW'(data);
        @(posedge clki);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input logic [NCH-1:0] e, input int n);
        for (int k = 0; k < n; k++) cyc(e, 1'b0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;  en = '0;  cfg_we = 1'b0;
        cfg_ch = '0;  cfg_sel = '0;  cfg_data = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clki);
        check_all();
        en = 3'b111;
        rst_n = 1'b1;

        // Default waveforms: periods 8/4/2, high 4/2/1
        idle(3'b111, 17);

        // Ch0 P=5 mid-period: current period finishes at 8
        idle(3'b111, 2);
        cyc(3'b111, 1'b1, 0, 0, 5);
        idle(3'b111, 20);

        // Ch1 H=0 then H=10
        cyc(3'b111, 1'b1, 1, 1, 0);
        idle(3'b111, 8);
        cyc(3'b111, 1'b1, 1, 1, 10);
        idle(3'b111, 12);

        // Ch2 tick mode with P=1; clko[2] must equal wrap[2]
        cyc(3'b111, 1'b1, 2, 2, 1);
        cyc(3'b111, 1'b1, 2, 0, 1);
        for (int k = 0; k < 10; k++) begin
            cyc(3'b111, 1'b0, 0, 0, 0);
            n_tests++;
            assert (clko[2] === wrap[2]) else begin
                n_fail++;
                $error("FAIL tick_eq_wrap t=%0t clko2=%b wrap2=%b", $time, clko[2], wrap[2]);
            end
        end

        // Drop en[0] in cycle 2 of a period, reassert 3 cycles later
        begin
            int guard;
            guard = 0;
            while (pos[0] != 2 && guard < 20) begin
                idle(3'b111, 1);
                guard++;
            end
            n_tests++;
            assert (guard < 20) else begin
                n_fail++;
                $error("FAIL find_cycle2 observed=%0d expected<20", guard);
            end
        end
        idle(3'b110, 3);
        idle(3'b111, 10);

        // Async reset pulse between edges
        @(negedge clki);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        rst_n = 1'b1;
        cyc(3'b111, 1'b1, 5, 0, 3);   // out-of-range channel write
        idle(3'b111, 16);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic [NCH-1:0] e;
            e = en;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 11) == 0) e[c] = ~e[c];
            cyc(e, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 10)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tao_xung_n_kenh
`default_nettype wire

// File: doc/tao_xung_n_kenh.md
TAO_XUNG_N_KENH -- requirements
Module: tao_xung_n_kenh

Interface
REQ-001 Parameter NCH, default 3, number of independent output channels (1..16).
REQ-002 Parameter CW, default 32, width of per-channel period/high-time counters.
REQ-003 Parameter DIV0, default 100000000, reset period of channel 0; channel i resets to period DIV0>>i, high time (DIV0>>i)/2.
REQ-004 clki  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  NCH  per-channel run enable.
REQ-007 cfg_we  input  1  config write strobe, one write per asserted cycle.
REQ-008 cfg_ch  input  4  target channel index; index >= NCH ignored.
REQ-009 cfg_sel  input  2  0=period P, 1=high time H, 2=mode bit (cfg_data[0]: 0 square, 1 tick), 3=reserved (ignored).
REQ-010 cfg_data  input  CW  write value.
REQ-011 clko  output  NCH  registered channel waveforms.
REQ-012 wrap  output  NCH  registered one-cycle strobe marking cycle 0 of each period.

Function
REQ-013 Each channel SHALL hold shadow registers (P, H, mode) written by cfg and active registers used by the counter.
REQ-014 Shadow-to-active copy SHALL occur only at a period boundary (counter wrap) or while en[i]=0, so no output glitch or truncated period arises from a write.
REQ-015 Effective period Pe = max(P_active, 2) cycles; P values 0 and 1 SHALL behave as 2.
REQ-016 On the first rising edge sampling en[i]=1 after en[i]=0, the counter SHALL load 0 and that cycle SHALL be cycle 0 of a period.
REQ-017 The counter SHALL increment 0..Pe-1 and wrap to 0; no other sequence is legal.
REQ-018 Square mode: clko[i] SHALL be 1 during cycles 0..H-1 of each period, 0 otherwise; H=0 gives constant 0; H>=Pe gives constant 1.
REQ-019 Tick mode: clko[i] SHALL be 1 only in cycle 0 of each period, ignoring H.
REQ-020 wrap[i] SHALL be 1 in cycle 0 of every period in both modes, including the first period after enable.
REQ-021 While en[i]=0: counter held at 0, clko[i]=0, wrap[i]=0; shadow writes still accepted.
REQ-022 en[i] deasserted mid-period SHALL force clko[i]=0 and wrap[i]=0 on the next edge; no completion of the period.
REQ-023 Write to a channel coinciding with its wrap edge SHALL be captured in shadow and take effect at the following wrap, not the current one.
REQ-024 Channels SHALL be fully independent; a write or enable on one channel SHALL not change timing of any other.

Reset
REQ-025 rst_n low SHALL asynchronously clear all counters to 0, clko and wrap to 0, mode to square, and load shadow and active P/H with the REQ-003 defaults.
REQ-026 Reset asserted mid-operation SHALL take effect without a clock edge; the first edge after release with en[i]=1 SHALL start cycle 0.

Structure
REQ-027 Package tao_xung_pkg SHALL hold cfg_sel encodings (SEL_P, SEL_H, SEL_MODE), mode encodings (MODE_SQUARE, MODE_TICK) and the minimum period constant (2).
REQ-028 One sub-module, chia_xung_kenh (one channel: shadow/active registers, counter, output logic), SHALL be instantiated NCH times via generate; top holds only cfg decode.

Verification (NCH=3, CW=8, DIV0=8)
REQ-029 Reset release, en=3'b111 -> clko[0] period 8 high 4, clko[1] period 4 high 2, clko[2] period 2 high 1; wrap[i] high every Pe cycles starting first enabled cycle.
REQ-030 Write ch0 P=5 mid-period -> current period remains 8 cycles; next period 5 cycles, high 4 cycles.
REQ-031 Ch1 H=0 then H=10 (P=4) -> constant 0 after next wrap, then constant 1 after following wrap; wrap still every 4 cycles.
REQ-032 Ch2 mode=tick, P=1 -> clko[2] one-cycle pulse every 2 cycles, equal to wrap[2].
REQ-033 Drop en[0] in cycle 2 of a period, reassert 3 cycles later -> clko[0]/wrap[0] 0 next edge; restart with wrap[0]=1 on first re-enabled edge.
REQ-034 rst_n low for 1 ns between edges mid-run -> outputs 0 immediately; defaults restored (ch0 P=8, H=4), writes lost; cfg_ch=5 write -> no channel changes.
